// File: rtl/rtc_pkg.sv
// Shared field widths, limits and time helpers for the time-of-day counter.
package rtc_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    localparam int unsigned HR_W  = 5;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned BIN_W = 7;

    typedef struct packed {
        logic [HR_W-1:0]  hours;
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
    } rtc_time_t;

    function automatic logic time_valid(input rtc_time_t t);
        return (t.hours   <= HR_W'(HR_MAX))  &&
               (t.minutes <= MIN_W'(MIN_MAX)) &&
               (t.seconds <= SEC_W'(SEC_MAX));
    endfunction

    // One-second increment with seconds->minutes->hours carry and midnight wrap.
    function automatic rtc_time_t time_inc(input rtc_time_t t);
        rtc_time_t r;
        r = t;
        if (t.seconds >= SEC_W'(SEC_MAX)) begin
            r.seconds = '0;
            if (t.minutes >= MIN_W'(MIN_MAX)) begin
                r.minutes = '0;
                r.hours   = (t.hours >= HR_W'(HR_MAX)) ? '0 : t.hours + HR_W'(1);
            end else begin
                r.minutes = t.minutes + MIN_W'(1);
            end
        end else begin
            r.seconds = t.seconds + SEC_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_clock_alarm_if.sv
// Control, load, alarm and display bundle between the RTC and its users.
interface rtc_clock_alarm_if #(
    parameter int unsigned DIV_W = 32
);
    import rtc_pkg::*;

    logic [DIV_W-1:0] clock_frequency;
    logic             run;
    logic             mode_12h;
    logic             set_valid;
    logic [HR_W-1:0]  set_hours;
    logic [MIN_W-1:0] set_minutes;
    logic [SEC_W-1:0] set_seconds;
    logic             set_err;
    logic             alarm_en;
    logic [HR_W-1:0]  alarm_hours;
    logic [MIN_W-1:0] alarm_minutes;
    logic             alarm_ack;
    logic             alarm_fire;
    logic             sec_tick;
    logic [HR_W-1:0]  hours_bin;
    logic [MIN_W-1:0] minutes_bin;
    logic [SEC_W-1:0] seconds_bin;
    logic             pm;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] hour_ones;
    logic [BCD_W-1:0] hour_tens;

    modport master (
        output clock_frequency, run, mode_12h,
        output set_valid, set_hours, set_minutes, set_seconds,
        output alarm_en, alarm_hours, alarm_minutes, alarm_ack,
        input  set_err, alarm_fire, sec_tick,
        input  hours_bin, minutes_bin, seconds_bin, pm,
        input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens
    );

    modport slave (
        input  clock_frequency, run, mode_12h,
        input  set_valid, set_hours, set_minutes, set_seconds,
        input  alarm_en, alarm_hours, alarm_minutes, alarm_ack,
        output set_err, alarm_fire, sec_tick,
        output hours_bin, minutes_bin, seconds_bin, pm,
        output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens
    );

endinterface

// File: rtl/bin2bcd_2d.sv
// Two-digit binary (0-99) to BCD tens/ones converter, purely combinational.
module bin2bcd_2d
    import rtc_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    always_comb begin
        tens = BCD_W'(bin / BIN_W'(10));
        ones = BCD_W'(bin % BIN_W'(10));
    end

endmodule

// File: rtl/rtc_clock_alarm.sv
// Time-of-day counter with programmable 1 Hz divider, time load, 12/24 h display
// and a single sticky alarm.
module rtc_clock_alarm
    import rtc_pkg::*;
#(
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned ALARM_SEC = 0
) (
    input  logic             clk,
    input  logic             reset,
    rtc_clock_alarm_if.slave bus
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] period_c;
    logic             wrap_c;
    logic             tick_c;
    logic             load_ok_c;
    logic             alarm_match_c;
    logic             alarm_fields_ok_c;
    logic             sec_tick_q;
    logic             set_err_q;
    logic             alarm_fire_q;
    logic [HR_W-1:0]  hour_disp_c;
    rtc_time_t        time_q;
    rtc_time_t        time_inc_c;
    rtc_time_t        set_time_c;
    rtc_time_t        alarm_time_c;

    // Tick and load qualification; >= lets a shrunken period wrap on the next edge.
    always_comb begin
        period_c          = (bus.clock_frequency == '0) ? DIV_W'(1) : bus.clock_frequency;
        wrap_c            = (div_q >= (period_c - DIV_W'(1)));
        tick_c            = bus.run & wrap_c;
        set_time_c        = '{hours: bus.set_hours, minutes: bus.set_minutes, seconds: bus.set_seconds};
        load_ok_c         = bus.set_valid & time_valid(set_time_c);
        time_inc_c        = time_inc(time_q);
        alarm_time_c      = '{hours: bus.alarm_hours, minutes: bus.alarm_minutes,
                              seconds: SEC_W'(ALARM_SEC)};
        alarm_fields_ok_c = time_valid(alarm_time_c);
        alarm_match_c     = tick_c & ~load_ok_c & bus.alarm_en & alarm_fields_ok_c &
                            (time_inc_c == alarm_time_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            time_q       <= '0;
            sec_tick_q   <= 1'b0;
            set_err_q    <= 1'b0;
            alarm_fire_q <= 1'b0;
        end else begin
            sec_tick_q <= tick_c & ~load_ok_c;
            set_err_q  <= bus.set_valid & ~load_ok_c;

            if (load_ok_c) begin
                time_q <= set_time_c;
                div_q  <= '0;
            end else if (tick_c) begin
                time_q <= time_inc_c;
                div_q  <= '0;
            end else if (bus.run) begin
                div_q  <= div_q + DIV_W'(1);
            end

            // A fresh match beats a coincident acknowledge.
            if (alarm_match_c) begin
                alarm_fire_q <= 1'b1;
            end else if (bus.alarm_ack) begin
                alarm_fire_q <= 1'b0;
            end
        end
    end

    // 12-hour view maps 0 -> 12 and 13..23 -> 1..11 without touching stored time.
    always_comb begin
        hour_disp_c = time_q.hours;
        if (bus.mode_12h) begin
            if (time_q.hours == '0) begin
                hour_disp_c = HR_W'(12);
            end else if (time_q.hours > HR_W'(12)) begin
                hour_disp_c = time_q.hours - HR_W'(12);
            end
        end
    end

    assign bus.sec_tick    = sec_tick_q;
    assign bus.set_err     = set_err_q;
    assign bus.alarm_fire  = alarm_fire_q;
    assign bus.hours_bin   = time_q.hours;
    assign bus.minutes_bin = time_q.minutes;
    assign bus.seconds_bin = time_q.seconds;
    assign bus.pm          = (time_q.hours >= HR_W'(12));

    bin2bcd_2d u_bcd_sec (
        .bin  (BIN_W'(time_q.seconds)),
        .tens (bus.sec_tens),
        .ones (bus.sec_ones)
    );

    bin2bcd_2d u_bcd_min (
        .bin  (BIN_W'(time_q.minutes)),
        .tens (bus.min_tens),
        .ones (bus.min_ones)
    );

    bin2bcd_2d u_bcd_hour (
        .bin  (BIN_W'(hour_disp_c)),
        .tens (bus.hour_tens),
        .ones (bus.hour_ones)
    );

endmodule

// File: tb/tb_rtc_clock_alarm.sv
// Randomized and directed bench for rtc_clock_alarm against a seconds-of-day model.
module tb_rtc_clock_alarm;
    import rtc_pkg::*;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned ALARM_SEC = 0;
    localparam int          DAY       = 86400;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rtc_clock_alarm_if #(.DIV_W(DIV_W)) bus ();

    rtc_clock_alarm #(.DIV_W(DIV_W), .ALARM_SEC(ALARM_SEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: time as seconds since midnight, divider count, registered flags.
    int m_t    = 0;
    int m_div  = 0;
    bit m_fire = 1'b0;
    bit m_tick = 1'b0;
    bit m_err  = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_div = 0; m_fire = 1'b0; m_tick = 1'b0; m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int  p;
        int  h, mi, s, ah, am;
        bit  ok, tk, match;
        p  = (bus.clock_frequency == 0) ? 1 : int'(bus.clock_frequency);
        h  = int'(bus.set_hours);
        mi = int'(bus.set_minutes);
        s  = int'(bus.set_seconds);
        ah = int'(bus.alarm_hours);
        am = int'(bus.alarm_minutes);
        ok = bus.set_valid && h < 24 && mi < 60 && s < 60;
        tk = bus.run && (m_div >= p - 1);
        match = 1'b0;
        if (ok) begin
            m_t   = h * 3600 + mi * 60 + s;
            m_div = 0;
        end else if (tk) begin
            m_t   = (m_t + 1) % DAY;
            m_div = 0;
            match = bus.alarm_en && ah < 24 && am < 60 &&
                    (m_t == ah * 3600 + am * 60 + int'(ALARM_SEC));
        end else if (bus.run) begin
            m_div = m_div + 1;
        end
        m_tick = tk && !ok;
        m_err  = bus.set_valid && !ok;
        if (match) m_fire = 1'b1;
        else if (bus.alarm_ack) m_fire = 1'b0;
    endtask

    task automatic check_outputs();
        int h, mi, s, dh;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        dh = h;
        if (bus.mode_12h) dh = ((h % 12) == 0) ? 12 : (h % 12);
        check("hours_bin",   int'(bus.hours_bin),   h);
        check("minutes_bin", int'(bus.minutes_bin), mi);
        check("seconds_bin", int'(bus.seconds_bin), s);
        check("pm",          int'(bus.pm),          int'(h >= 12));
        check("sec_tick",    int'(bus.sec_tick),    int'(m_tick));
        check("set_err",     int'(bus.set_err),     int'(m_err));
        check("alarm_fire",  int'(bus.alarm_fire),  int'(m_fire));
        check("sec_bcd",     int'(bus.sec_tens) * 10 + int'(bus.sec_ones),  s);
        check("min_bcd",     int'(bus.min_tens) * 10 + int'(bus.min_ones),  mi);
        check("hour_bcd",    int'(bus.hour_tens) * 10 + int'(bus.hour_ones), dh);
        check("bcd_digits_ok", int'(bus.sec_ones < 10 && bus.min_ones < 10 && bus.hour_ones < 10), 1);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic load(input int h, input int mi, input int s);
        bus.set_valid   = 1'b1;
        bus.set_hours   = HR_W'(h);
        bus.set_minutes = MIN_W'(mi);
        bus.set_seconds = SEC_W'(s);
        step();
        bus.set_valid   = 1'b0;
    endtask

    // Steps until the model has seen n ticks, bounded; returns steps taken.
    task automatic run_ticks(input int n, output int steps);
        int seen;
        seen  = 0;
        steps = 0;
        while (seen < n && steps < 200) begin
            step();
            steps++;
            if (m_tick) seen++;
        end
        check("tick_budget", int'(seen == n), 1);
    endtask

    int n;
    int edge_no;

    initial begin
        bus.clock_frequency = DIV_W'(4);
        bus.run             = 1'b1;
        bus.mode_12h        = 1'b0;
        bus.set_valid       = 1'b0;
        bus.set_hours       = '0;
        bus.set_minutes     = '0;
        bus.set_seconds     = '0;
        bus.alarm_en        = 1'b0;
        bus.alarm_hours     = '0;
        bus.alarm_minutes   = '0;
        bus.alarm_ack       = 1'b0;

        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        reset = 1'b0;

        // First tick after release on the 4th edge with a period of 4.
        edge_no = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (m_tick && edge_no == 0) edge_no = i;
            if (bus.sec_tick && edge_no == 0) edge_no = -i;
        end
        check("first_tick_edge", edge_no, 4);

        // Asynchronous reset mid-count, including 12-hour reset display.
        bus.mode_12h = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("reset_hour_12h", int'(bus.hour_tens) * 10 + int'(bus.hour_ones), 12);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mode_12h = 1'b0;
        #1;
        check("reset_hour_24h", int'(bus.hour_tens) * 10 + int'(bus.hour_ones), 0);

        // Midnight rollover.
        bus.clock_frequency = DIV_W'(2);
        load(23, 59, 58);
        run_ticks(2, n);
        check("rollover_time", int'(bus.hours_bin) * 3600 + int'(bus.minutes_bin) * 60 + int'(bus.seconds_bin), 0);
        check("rollover_pm", int'(bus.pm), 0);

        // 12-hour display.
        bus.mode_12h = 1'b1;
        load(0, 30, 0);
        check("h12_midnight", int'(bus.hour_tens) * 10 + int'(bus.hour_ones), 12);
        load(13, 5, 0);
        check("h12_1pm", int'(bus.hour_tens) * 10 + int'(bus.hour_ones), 1);
        check("h12_pm", int'(bus.pm), 1);
        bus.mode_12h = 1'b0;
        #1;
        check("h24_switch", int'(bus.hour_tens) * 10 + int'(bus.hour_ones), 13);

        // Rejected load.
        load(24, 10, 0);
        check("bad_load_err", int'(bus.set_err), 1);
        check("bad_load_hours", int'(bus.hours_bin), 13);
        step();
        check("bad_load_err_once", int'(bus.set_err), 0);

        // Load on a tick edge wins and restarts the divider.
        load(1, 1, 1);
        step();
        load(10, 20, 30);
        check("coincident_load", int'(bus.seconds_bin), 30);
        step();
        check("coincident_div_restart", int'(bus.seconds_bin), 30);
        step();
        check("coincident_next_tick", int'(bus.seconds_bin), 31);

        // Alarm at 07:00:ALARM_SEC.
        bus.alarm_en      = 1'b1;
        bus.alarm_hours   = HR_W'(7);
        bus.alarm_minutes = MIN_W'(0);
        load(6, 59, 58);
        run_ticks(2, n);
        check("alarm_fire_2nd_tick", int'(bus.alarm_fire), 1);
        load(6, 59, 58);
        check("load_keeps_fire", int'(bus.alarm_fire), 1);
        bus.alarm_ack = 1'b1;
        step();
        check("alarm_ack_clear", int'(bus.alarm_fire), 0);
        load(6, 59, 58);
        step();
        bus.alarm_ack = 1'b1;
        step(); step(); step();
        check("ack_and_match_sets", int'(bus.alarm_fire), 1);
        bus.alarm_ack = 1'b1;
        load(6, 59, 58);
        bus.alarm_ack = 1'b0;
        bus.run = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("paused_no_alarm", int'(bus.alarm_fire), 0);
        check("paused_time", int'(bus.seconds_bin), 58);
        bus.run = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.clock_frequency = DIV_W'($urandom_range(0, 4));
            bus.run       = ($urandom_range(0, 7) != 0);
            bus.mode_12h  = $urandom_range(0, 1);
            bus.alarm_ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bus.alarm_en = $urandom_range(0, 3) != 0;
            bus.set_valid = 1'b0;
            if (i % 150 == 0) begin
                int ah, am, ts;
                ah = $urandom_range(0, 23);
                am = $urandom_range(0, 62);
                bus.alarm_hours   = HR_W'(ah);
                bus.alarm_minutes = MIN_W'(am);
                ts = (ah * 3600 + am * 60 + int'(ALARM_SEC) - int'($urandom_range(1, 4)) + DAY) % DAY;
                bus.set_valid   = 1'b1;
                bus.set_hours   = HR_W'(ts / 3600);
                bus.set_minutes = MIN_W'((ts / 60) % 60);
                bus.set_seconds = SEC_W'(ts % 60);
            end else if ($urandom_range(0, 59) == 0) begin
                bus.set_valid   = 1'b1;
                bus.set_hours   = HR_W'($urandom_range(0, 25));
                bus.set_minutes = MIN_W'($urandom_range(0, 61));
                bus.set_seconds = SEC_W'($urandom_range(0, 61));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
